// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Optional break detection is enabled with UART_RX_BREAK_DETECT_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_COMPLETE
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    function automatic int unsigned uart_clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Host-side character handshake and status bundle of uart_rx_param.
// break_det exists only when UART_RX_BREAK_DETECT_EN is defined.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                 break_det;

    modport master (
        output data_out, data_valid, parity_err, frame_err, overrun_err, busy, break_det,
        input  data_ready
    );
    modport slave (
        input  data_out, data_valid, parity_err, frame_err, overrun_err, busy, break_det,
        output data_ready
    );
`else
    modport master (
        output data_out, data_valid, parity_err, frame_err, overrun_err, busy,
        input  data_ready
    );
    modport slave (
        input  data_out, data_valid, parity_err, frame_err, overrun_err, busy,
        output data_ready
    );
`endif
endinterface

// File: rtl/uart_rx_sampler.sv
// RX line conditioning: 2-flop synchroniser, falling-edge detect and a
// 3-sample majority vote around mid-bit, timed by the parent's clk_cnt.
module uart_rx_sampler #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_in,
    input  logic [15:0] clk_cnt,
    output logic        rx_s,
    output logic        fall,
    output logic        maj_bit,
    output logic        maj_vld
);
    localparam logic [15:0] MID = 16'(CLKS_PER_BIT / 2);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic vote0_q, vote0_d;
    logic vote1_q, vote1_d;

    always_comb begin
        sync1_d = data_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        vote0_d = (clk_cnt == MID - 16'd1) ? sync2_q : vote0_q;
        vote1_d = (clk_cnt == MID)         ? sync2_q : vote1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            vote0_q <= 1'b1;
            vote1_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            vote0_q <= vote0_d;
            vote1_q <= vote1_d;
        end
    end

    // Third vote is the live synchronised line at MID+1.
    assign rx_s    = sync2_q;
    assign fall    = prev_q & ~sync2_q;
    assign maj_vld = (clk_cnt == MID + 16'd1);
    assign maj_bit = (vote0_q & vote1_q) | (vote0_q & sync2_q) | (vote1_q & sync2_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver delivering characters over a valid/ready bundle.
// Define UART_RX_BREAK_DETECT_EN to add break_det and discard break frames.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            data_in,
    uart_rx_param_if.master rx_if
);
    localparam int unsigned       BIT_W     = uart_clog2(DATA_BITS + 1);
    localparam logic [15:0]       CNT_MAX   = 16'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_INV   = (PARITY_MODE == PARITY_ODD);

    uart_state_e          state_q, state_d;
    logic [15:0]          clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 parity_pulse_q, parity_pulse_d;
    logic                 frame_pulse_q, frame_pulse_d;
    logic                 overrun_pulse_q, overrun_pulse_d;
    logic                 deliver;

    logic rx_s, fall, maj_bit, maj_vld;

    uart_rx_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_sampler (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (data_in),
        .clk_cnt (clk_cnt_q),
        .rx_s    (rx_s),
        .fall    (fall),
        .maj_bit (maj_bit),
        .maj_vld (maj_vld)
    );

`ifdef UART_RX_BREAK_DETECT_EN
    localparam int unsigned      BRK_CYCLES = (DATA_BITS + 3) * CLKS_PER_BIT;
    localparam int unsigned      LOW_W      = uart_clog2(BRK_CYCLES + 1);
    localparam logic [LOW_W-1:0] BRK_LAST   = LOW_W'(BRK_CYCLES - 1);
    localparam logic [LOW_W-1:0] BRK_SAT    = LOW_W'(BRK_CYCLES);

    logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
    logic             brk_seen_q, brk_seen_d;
    logic             brk_det_q, brk_det_d;
    logic             brk_hit;

    // Counter saturates so a held break pulses break_det only once.
    always_comb begin
        brk_hit    = !rx_s && (low_cnt_q == BRK_LAST);
        low_cnt_d  = rx_s ? '0 : ((low_cnt_q == BRK_SAT) ? low_cnt_q : low_cnt_q + LOW_W'(1));
        brk_seen_d = (state_q == ST_IDLE && fall) ? 1'b0 : (brk_seen_q | brk_hit);
        brk_det_d  = brk_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_q  <= '0;
            brk_seen_q <= 1'b0;
            brk_det_q  <= 1'b0;
        end else begin
            low_cnt_q  <= low_cnt_d;
            brk_seen_q <= brk_seen_d;
            brk_det_q  <= brk_det_d;
        end
    end

    assign rx_if.break_det = brk_det_q;
`endif

    always_comb begin
        state_d         = state_q;
        clk_cnt_d       = '0;
        bit_cnt_d       = bit_cnt_q;
        shift_d         = shift_q;
        par_err_d       = par_err_q;
        frm_err_d       = frm_err_q;
        data_out_d      = data_out_q;
        data_valid_d    = data_valid_q;
        parity_pulse_d  = 1'b0;
        frame_pulse_d   = 1'b0;
        overrun_pulse_d = 1'b0;
        deliver         = 1'b0;

        if (data_valid_q && rx_if.data_ready) data_valid_d = 1'b0;

        if (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
            clk_cnt_d = (clk_cnt_q == CNT_MAX) ? '0 : clk_cnt_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (fall && !rx_s) begin
                    state_d   = ST_START;
                    bit_cnt_d = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (maj_vld) state_d = maj_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (maj_vld) begin
                    shift_d = {maj_bit, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (maj_vld) begin
                    par_err_d = (^shift_q) ^ maj_bit ^ PAR_INV;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (maj_vld) begin
                    if (!maj_bit) frm_err_d = 1'b1;
                    if (bit_cnt_q == STOP_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = ST_COMPLETE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_COMPLETE: begin
`ifdef UART_RX_BREAK_DETECT_EN
                // A low stop bit may be the start of a break: hold until the
                // line recovers (deliver) or the break threshold is reached (discard).
                if (brk_seen_q || brk_hit)      state_d = ST_IDLE;
                else if (frm_err_q && !rx_s)    state_d = ST_COMPLETE;
                else                            deliver = 1'b1;
`else
                deliver = 1'b1;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (deliver) begin
            state_d        = ST_IDLE;
            parity_pulse_d = par_err_q;
            frame_pulse_d  = frm_err_q;
            if (!data_valid_q || rx_if.data_ready) begin
                data_out_d   = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_pulse_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            clk_cnt_q       <= '0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            par_err_q       <= 1'b0;
            frm_err_q       <= 1'b0;
            data_out_q      <= '0;
            data_valid_q    <= 1'b0;
            parity_pulse_q  <= 1'b0;
            frame_pulse_q   <= 1'b0;
            overrun_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clk_cnt_q       <= clk_cnt_d;
            bit_cnt_q       <= bit_cnt_d;
            shift_q         <= shift_d;
            par_err_q       <= par_err_d;
            frm_err_q       <= frm_err_d;
            data_out_q      <= data_out_d;
            data_valid_q    <= data_valid_d;
            parity_pulse_q  <= parity_pulse_d;
            frame_pulse_q   <= frame_pulse_d;
            overrun_pulse_q <= overrun_pulse_d;
        end
    end

    assign rx_if.data_out    = data_out_q;
    assign rx_if.data_valid  = data_valid_q;
    assign rx_if.parity_err  = parity_pulse_q;
    assign rx_if.frame_err   = frame_pulse_q;
    assign rx_if.overrun_err = overrun_pulse_q;
    assign rx_if.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and an even-parity instance.
// Build with UART_RX_BREAK_DETECT_EN to cover break_det.
module tb_uart_rx_param;

    localparam int CPB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic line0 = 1'b1;
    logic line1 = 1'b1;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) if0 ();
    uart_rx_param_if #(.DATA_BITS(8)) if1 ();

    uart_rx_param #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_MODE  (0),
        .STOP_BITS    (1)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (line0),
        .rx_if   (if0)
    );

    uart_rx_param #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY_MODE  (1),
        .STOP_BITS    (1)
    ) u_dut_par (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_in (line1),
        .rx_if   (if1)
    );

    logic       mon_busy[2], mon_valid[2], mon_par[2], mon_frm[2], mon_ovr[2];
    logic [7:0] mon_data[2];

    always_comb begin
        mon_busy[0] = if0.busy;        mon_busy[1] = if1.busy;
        mon_valid[0] = if0.data_valid; mon_valid[1] = if1.data_valid;
        mon_par[0] = if0.parity_err;   mon_par[1] = if1.parity_err;
        mon_frm[0] = if0.frame_err;    mon_frm[1] = if1.frame_err;
        mon_ovr[0] = if0.overrun_err;  mon_ovr[1] = if1.overrun_err;
        mon_data[0] = if0.data_out;    mon_data[1] = if1.data_out;
    end

    typedef struct {
        int         dut;
        logic       valid;
        logic [7:0] data;
        logic       par;
        logic       frm;
        logic       ovr;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks   = 0;
    int         failures = 0;
    bit         model_valid[2];
    logic [7:0] model_data[2];
    bit         busy_prev[2];
    int         busy_len[2];
    int         last_len[2];
    int         brk_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Frame end is the busy falling edge; outputs for that frame are visible on the same cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                busy_prev[d] = 1'b0;
                busy_len[d]  = 0;
            end else begin
                if (busy_prev[d] && !mon_busy[d]) begin
                    last_len[d] = busy_len[d];
                    busy_len[d] = 0;
                    check_eq("sb_has_item", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        check_eq("sb_dut", d, mon_e.dut);
                        check_eq("sb_valid", mon_valid[d], mon_e.valid);
                        if (mon_e.valid) check_eq("sb_data", mon_data[d], mon_e.data);
                        check_eq("sb_parity_err", mon_par[d], mon_e.par);
                        check_eq("sb_frame_err", mon_frm[d], mon_e.frm);
                        check_eq("sb_overrun_err", mon_ovr[d], mon_e.ovr);
                    end
                end else begin
                    if (mon_busy[d]) busy_len[d]++;
                    if (mon_par[d] | mon_frm[d] | mon_ovr[d])
                        check_eq("stray_pulse", {mon_par[d], mon_frm[d], mon_ovr[d]}, 0);
                end
                busy_prev[d] = mon_busy[d];
            end
        end
`ifdef UART_RX_BREAK_DETECT_EN
        if (if0.break_det) brk_cnt++;
`endif
    end

    task automatic push_frame(input int d, input logic [7:0] data, input logic par, input logic frm);
        exp_t e;
        logic ovr;
        ovr = 1'b0;
        if (!model_valid[d]) begin
            model_valid[d] = 1'b1;
            model_data[d]  = data;
        end else begin
            ovr = 1'b1;
        end
        e = '{dut: d, valid: 1'b1, data: model_data[d], par: par, frm: frm, ovr: ovr};
        exp_q.push_back(e);
    endtask

    task automatic push_discard(input int d);
        exp_t e;
        e = '{dut: d, valid: model_valid[d], data: model_data[d], par: 1'b0, frm: 1'b0, ovr: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input int d, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (d == 0) line0 = bits[i];
            else        line1 = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic idle(input int d, input int cycles);
        if (d == 0) line0 = 1'b1;
        else        line1 = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send8(input logic [7:0] data, input logic stop);
        send_bits(0, {6'b0, stop, data, 1'b0}, 10);
    endtask

    task automatic send_par(input logic [7:0] data, input logic p);
        send_bits(1, {5'b0, 1'b1, p, data, 1'b0}, 11);
    endtask

    task automatic accept(input int d);
        @(negedge clk);
        check_eq("acc_valid", mon_valid[d], 1);
        check_eq("acc_data", mon_data[d], model_data[d]);
        if (d == 0) if0.data_ready = 1'b1;
        else        if1.data_ready = 1'b1;
        @(negedge clk);
        if0.data_ready = 1'b0;
        if1.data_ready = 1'b0;
        check_eq("acc_cleared", mon_valid[d], 0);
        model_valid[d] = 1'b0;
    endtask

    initial begin
        if0.data_ready = 1'b0;
        if1.data_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", if0.data_valid, 0);
        check_eq("rst_data", if0.data_out, 0);
        check_eq("rst_busy", if0.busy, 0);
        check_eq("rst_pulses", {if0.parity_err, if0.frame_err, if0.overrun_err}, 0);
        check_eq("rst_busy_par", if1.busy, 0);
        rst_n = 1'b1;
        idle(0, 5);

        // Plain 8N1 character, held until accepted
        push_frame(0, 8'hA5, 1'b0, 1'b0);
        send8(8'hA5, 1'b1);
        idle(0, 40);
        check_eq("hold_valid", mon_valid[0], 1);
        accept(0);

        // Even parity: 0x03 has an even number of ones, so parity bit 1 is wrong
        push_frame(1, 8'h03, (^8'h03) ^ 1'b1, 1'b0);
        send_par(8'h03, 1'b1);
        idle(1, 20);
        accept(1);
        push_frame(1, 8'h03, (^8'h03) ^ 1'b0, 1'b0);
        send_par(8'h03, 1'b0);
        idle(1, 20);
        accept(1);

        // Framing error then clean recovery
        push_frame(0, 8'h5A, 1'b0, 1'b1);
        send8(8'h5A, 1'b0);
        idle(0, 20);
        accept(0);
        push_frame(0, 8'h3C, 1'b0, 1'b0);
        send8(8'h3C, 1'b1);
        idle(0, 20);
        accept(0);

        // Short glitch is a false start
        push_discard(0);
        line0 = 1'b0;
        repeat (4) @(negedge clk);
        idle(0, 40);
        check_eq("glitch_busy_short", 32'(last_len[0] > 0 && last_len[0] < CPB), 1);
        check_eq("glitch_no_valid", mon_valid[0], 0);

        // Back-to-back with consumer stalled: second frame overruns
        push_frame(0, 8'h11, 1'b0, 1'b0);
        send8(8'h11, 1'b1);
        push_frame(0, 8'h22, 1'b0, 1'b0);
        send8(8'h22, 1'b1);
        idle(0, 20);
        accept(0);

        // Reset mid-frame with a character pending
        push_frame(0, 8'h81, 1'b0, 1'b0);
        send8(8'h81, 1'b1);
        idle(0, 20);
        send_bits(0, 16'b0110, 4);
        #3 rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", if0.data_valid, 0);
        check_eq("midrst_data", if0.data_out, 0);
        check_eq("midrst_busy", if0.busy, 0);
        check_eq("midrst_pulses", {if0.parity_err, if0.frame_err, if0.overrun_err}, 0);
        model_valid[0] = 1'b0;
        line0 = 1'b1;
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        idle(0, 10);
        push_frame(0, 8'h7E, 1'b0, 1'b0);
        send8(8'h7E, 1'b1);
        idle(0, 20);
        accept(0);

        // Break: line held low for 12 bit times
`ifdef UART_RX_BREAK_DETECT_EN
        push_discard(0);
`else
        push_frame(0, 8'h00, 1'b0, 1'b1);
`endif
        line0 = 1'b0;
        repeat (12 * CPB) @(negedge clk);
        idle(0, 40);
`ifdef UART_RX_BREAK_DETECT_EN
        check_eq("break_det_count", brk_cnt, 1);
        check_eq("break_no_valid", mon_valid[0], 0);
`else
        accept(0);
`endif

        idle(0, 10);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
